// File: rtl/rbm_result_reader.sv
// rtl/rbm_result_reader.sv - captures RBM class scores, scans for the argmax, optionally streams scores out
// Optional score stream enabled by defining RBM_RESULT_STREAM_EN.
module rbm_result_reader #(
  parameter int output_dim = 10,
  parameter int bitlength  = 12,
  parameter int idx_width  = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            finish,
  input  logic [output_dim*bitlength-1:0] OutputDataPort,
  output logic                            busy,
  output logic                            class_valid,
  output logic [idx_width-1:0]            class_idx,
  output logic [bitlength-1:0]            class_score,
  output logic                            overrun,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [bitlength-1:0]            out_data,
  output logic                            out_last
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [idx_width-1:0] last_idx  = idx_width'(output_dim - 1);
  localparam logic [bitlength-1:0] min_score = {1'b1, {(bitlength-1){1'b0}}};

  state_t               state_q, state_d;
  logic                 finish_q;
  logic [bitlength-1:0] buf_q [output_dim];
  logic [idx_width-1:0] idx_q;
  logic [idx_width-1:0] best_idx_q;
  logic [bitlength-1:0] best_score_q;
  logic                 capture;
  logic [bitlength-1:0] cur_score;
  logic                 better;
  logic                 scan_done;

  assign capture   = finish && !finish_q;
  assign cur_score = buf_q[idx_q];
  assign better    = $signed(cur_score) > $signed(best_score_q);
  assign scan_done = (state_q == SCAN) && (idx_q == last_idx);
  assign busy      = (state_q != IDLE);

`ifdef RBM_RESULT_STREAM_EN
  logic [idx_width-1:0] str_j_q;
  logic                 str_last;
  logic                 str_fire;

  assign out_valid = (state_q == STREAM);
  assign str_last  = (str_j_q == last_idx);
  assign str_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? buf_q[str_j_q] : '0;
  assign out_last  = out_valid && str_last;
`else
  logic stream_unused;

  assign stream_unused = out_ready;
  assign out_valid     = 1'b0;
  assign out_data      = '0;
  assign out_last      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (capture) state_d = SCAN;
`ifdef RBM_RESULT_STREAM_EN
      SCAN:   if (scan_done) state_d = STREAM;
      STREAM: if (str_fire && str_last) state_d = IDLE;
`else
      SCAN:   if (scan_done) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Captures arriving while busy only flag overrun; the buffer stays untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      finish_q     <= 1'b0;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      class_valid  <= 1'b0;
      class_idx    <= '0;
      class_score  <= '0;
      overrun      <= 1'b0;
      for (int i = 0; i < output_dim; i++) buf_q[i] <= '0;
`ifdef RBM_RESULT_STREAM_EN
      str_j_q      <= '0;
`endif
    end else begin
      finish_q    <= finish;
      class_valid <= 1'b0;
      if (capture) begin
        if (state_q == IDLE) begin
          for (int i = 0; i < output_dim; i++) buf_q[i] <= OutputDataPort[i*bitlength +: bitlength];
          idx_q        <= '0;
          best_idx_q   <= '0;
          best_score_q <= min_score;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (state_q == SCAN) begin
        if (better) begin
          best_idx_q   <= idx_q;
          best_score_q <= cur_score;
        end
        if (scan_done) begin
          idx_q       <= '0;
          class_valid <= 1'b1;
          class_idx   <= better ? idx_q : best_idx_q;
          class_score <= better ? cur_score : best_score_q;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
`ifdef RBM_RESULT_STREAM_EN
      if (str_fire) str_j_q <= str_last ? '0 : str_j_q + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_rbm_result_reader.sv
// tb/tb_rbm_result_reader.sv - scoreboard bench for rbm_result_reader
module tb_rbm_result_reader;
  localparam int N = 10;
  localparam int W = 12;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           finish = 1'b0;
  logic [N*W-1:0] data = '0;
  logic           busy, class_valid, overrun, out_valid, out_ready, out_last;
  logic [3:0]     class_idx;
  logic [W-1:0]   class_score, out_data;

  rbm_result_reader #(.output_dim(N), .bitlength(W), .idx_width(4)) dut (
    .clock(clock), .reset(reset), .finish(finish), .OutputDataPort(data),
    .busy(busy), .class_valid(class_valid), .class_idx(class_idx),
    .class_score(class_score), .overrun(overrun), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int exp_idx_q[$];
  int exp_score_q[$];
  int exp_data_q[$];
  int exp_last_q[$];
  int vec[N];
  int busy_cnt = 0;
  int out_valid_seen = 0;
  bit bp_mode = 1'b0;
  int bp_k = 0;
  bit prev_stall = 1'b0;
  int prev_data = 0;
  bit pending_idle = 1'b0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // out_ready pattern 1,0,0,1 repeating in backpressure mode
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (bp_mode) begin
        out_ready = (bp_k == 0 || bp_k == 3);
        bp_k = (bp_k + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      prev_stall   = 1'b0;
      pending_idle = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (out_valid) out_valid_seen++;
      if (pending_idle) begin
        check("idle_after_last_busy", int'(busy), 0);
        check("idle_after_last_valid", int'(out_valid), 0);
        pending_idle = 1'b0;
      end
      if (prev_stall) begin
        check("stream_hold_valid", int'(out_valid), 1);
        check("stream_hold_data", int'($signed(out_data)), prev_data);
      end
      if (class_valid) begin
        if (exp_idx_q.size() == 0) begin
          check("class_unexpected", 1, 0);
        end else begin
          check("class_idx", int'(class_idx), exp_idx_q.pop_front());
          check("class_score", int'($signed(class_score)), exp_score_q.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          check("stream_unexpected", 1, 0);
        end else begin
          check("stream_data", int'($signed(out_data)), exp_data_q.pop_front());
          check("stream_last", int'(out_last), exp_last_q.pop_front());
        end
        if (out_last) pending_idle = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = int'($signed(out_data));
    end
  end

  task automatic load_vec();
    for (int i = 0; i < N; i++) data[i*W +: W] = vec[i][W-1:0];
  endtask

  task automatic push_expect(int e_idx, int e_score);
    exp_idx_q.push_back(e_idx);
    exp_score_q.push_back(e_score);
`ifdef RBM_RESULT_STREAM_EN
    for (int i = 0; i < N; i++) begin
      exp_data_q.push_back(vec[i]);
      exp_last_q.push_back(i == N - 1);
    end
`endif
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (busy) check(name, 1, 0);
  endtask

  task automatic run_result(int e_idx, int e_score);
    int cnt;
    load_vec();
    push_expect(e_idx, e_score);
    @(posedge clock);
    #1;
    busy_cnt = 0;
    finish = 1'b1;
    cnt = 0;
    do begin
      @(posedge clock);
      #1;
      cnt++;
      if (cnt == 1) data = {N*W{1'b1}} ^ data;
    end while (!class_valid && cnt < 50);
    check("class_latency", cnt, 11);
    wait_idle("busy_timeout");
    finish = 1'b0;
    repeat (2) @(posedge clock);
    #1;
`ifndef RBM_RESULT_STREAM_EN
    check("busy_cycles", busy_cnt, 10);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_class_valid", int'(class_valid), 0);
    check("rst_class_idx", int'(class_idx), 0);
    check("rst_class_score", int'(class_score), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    vec = '{5, -3, 100, 7, 0, 0, 0, 0, 0, -2048};
    run_result(2, 100);
    check("overrun_clear", int'(overrun), 0);

    vec = '{-5, -5, -5, -5, 2047, -5, -5, 2047, -5, -5};
    run_result(4, 2047);

    vec = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
    run_result(0, -2048);

    bp_mode = 1'b1;
    vec = '{10, -20, 30, -40, 50, -60, 70, -80, 90, -100};
    run_result(8, 90);
    bp_mode = 1'b0;

    vec = '{5, -3, 100, 7, 0, 0, 0, 0, 0, -2048};
    load_vec();
    push_expect(2, 100);
    @(posedge clock);
    #1;
    finish = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    finish = 1'b0;
    data[0 +: W] = 12'd2047;
    @(posedge clock);
    #1;
    finish = 1'b1;
    @(posedge clock);
    #1;
    check("overrun_set", int'(overrun), 1);
    wait_idle("overrun_busy_timeout");
    repeat (15) @(posedge clock);
    #1;
    check("held_finish_no_capture", int'(busy), 0);
    check("overrun_sticky", int'(overrun), 1);
    finish = 1'b0;

    vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    load_vec();
    @(posedge clock);
    #1;
    finish = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_class_valid", int'(class_valid), 0);
    check("abort_class_idx", int'(class_idx), 0);
    check("abort_class_score", int'(class_score), 0);
    check("abort_overrun", int'(overrun), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_data", int'(out_data), 0);
    check("abort_out_last", int'(out_last), 0);
    finish = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (15) @(posedge clock);
    #1;
    vec = '{5, -3, 100, 7, 0, 0, 0, 0, 0, -2048};
    run_result(2, 100);

    repeat (3) @(posedge clock);
    #1;
    check("class_queue_empty", exp_idx_q.size(), 0);
    check("stream_queue_empty", exp_data_q.size(), 0);
`ifndef RBM_RESULT_STREAM_EN
    check("out_valid_never", out_valid_seen, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
